// File: rtl/stack_dn_lane_sync_if.sv
// Bundle of OOB command, per-lane input and lockstep output signals.
// Latency: none, wires only.
// Backpressure: valid/ready on every channel; slave is the synchroniser.
interface stack_dn_lane_sync_if #(
  parameter int NUM_LANES = 32,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16
) ();
  logic                        oob_valid;
  logic                        oob_ready;
  logic [NUM_LANES-1:0]        oob_lane_mask;
  logic [CNT_W-1:0]            oob_num_words;
  logic [NUM_LANES-1:0]        lane_valid;
  logic [NUM_LANES-1:0]        lane_ready;
  logic [NUM_LANES*DATA_W-1:0] lane_data;
  logic [NUM_LANES*2-1:0]      lane_cntl;
  logic                        out_valid;
  logic                        out_ready;
  logic [NUM_LANES*DATA_W-1:0] out_data;
  logic [1:0]                  out_cntl;
  logic                        op_done;
  logic                        cntl_err;

  modport master (
    output oob_valid, oob_lane_mask, oob_num_words,
    output lane_valid, lane_data, lane_cntl, out_ready,
    input  oob_ready, lane_ready, out_valid, out_data, out_cntl, op_done, cntl_err
  );

  modport slave (
    input  oob_valid, oob_lane_mask, oob_num_words,
    input  lane_valid, lane_data, lane_cntl, out_ready,
    output oob_ready, lane_ready, out_valid, out_data, out_cntl, op_done, cntl_err
  );
endinterface

// File: rtl/stack_dn_lane_sync.sv
// Downstream stack-bus lane synchroniser: per-lane FIFOs released in lockstep per OOB command.
// Latency: 1 cycle push-to-pop minimum (no bypass); op_done 1 cycle after the last fire.
// Backpressure: lane_ready drops when a lane FIFO is full; out_valid holds until out_ready.
// Optional macro LANE_CNTL_CHECK_EN builds the sticky lane-control mismatch check (cntl_err).

// Generic single-clock FIFO with extra-MSB wrap pointers.
// Latency: 1 cycle, head visible the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored.
module stack_dn_lane_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset_poweron,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         push_ok, pop_ok;

  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign push_ok  = push_vld & ~full;
  assign pop_ok   = pop_rdy & ~empty;
  assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

  // Advance pointers on accepted push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: contents are only observed behind a valid pointer.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end
  end
endmodule

// Lockstep release of the enabled lanes as one wide word per OOB operation.
// Latency: 1 cycle from last lane push to out_valid; op_done 1 cycle after final fire.
// Backpressure: out_ready low freezes all heads; full lanes deassert lane_ready.
module stack_dn_lane_sync #(
  parameter int NUM_LANES = 32,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset_poweron,
  stack_dn_lane_sync_if.slave bus
);
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                      state_q, state_d;
  logic [NUM_LANES-1:0]        mask_q, mask_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  logic [NUM_LANES-1:0]        full, empty, push, pop, lane_rdy;
  logic [DATA_W+1:0]           push_dat [NUM_LANES];
  logic [DATA_W+1:0]           head_dat [NUM_LANES];
  logic                        streaming, oob_acc, out_vld, fire, last;
  logic                        oob_rdy, op_done_c;
  logic [1:0]                  low_cntl, out_cntl_c;
  logic [NUM_LANES*DATA_W-1:0] out_dat;

  assign streaming = (state_q == STREAM);
  assign oob_acc   = bus.oob_valid & (state_q == IDLE);
  assign last      = (cnt_q == (count_q - CNT_ONE));

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign push[g]     = bus.lane_valid[g] & lane_rdy[g];
    assign pop[g]      = fire & mask_q[g];
    assign push_dat[g] = {bus.lane_cntl[2*g +: 2], bus.lane_data[g*DATA_W +: DATA_W]};

    stack_dn_lane_fifo #(
      .W     (DATA_W + 2),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk           (clk),
      .reset_poweron (reset_poweron),
      .push_vld      (push[g]),
      .push_dat      (push_dat[g]),
      .pop_rdy       (pop[g]),
      .head_dat      (head_dat[g]),
      .full          (full[g]),
      .empty         (empty[g])
    );
  end

  // State register; reset aborts any operation without op_done.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: zero-mask or zero-count commands complete immediately.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (oob_acc) begin
          if ((bus.oob_lane_mask == '0) || (bus.oob_num_words == '0)) begin
            state_d = DONE;
          end else begin
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        if (fire && last) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: handshakes, lowest-enabled-lane control and masked wide data.
  always_comb begin
    oob_rdy   = (state_q == IDLE);
    op_done_c = (state_q == DONE);
    lane_rdy  = {NUM_LANES{streaming}} & mask_q & ~full;
    out_vld   = streaming & (&(~mask_q | ~empty));
    fire      = out_vld & bus.out_ready;
    low_cntl  = 2'b00;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        low_cntl = head_dat[i][DATA_W +: 2];
      end
    end
    out_cntl_c = streaming ? low_cntl : 2'b00;
    out_dat    = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (streaming && mask_q[i]) begin
        out_dat[i*DATA_W +: DATA_W] = head_dat[i][DATA_W-1:0];
      end
    end
  end

  // Operation registers: latched on OOB accept, word counter steps per fire.
  always_comb begin
    mask_d  = mask_q;
    count_d = count_q;
    cnt_d   = cnt_q;
    if (oob_acc) begin
      mask_d  = bus.oob_lane_mask;
      count_d = bus.oob_num_words;
      cnt_d   = '0;
    end else if (fire) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Operation register update.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      mask_q  <= '0;
      count_q <= '0;
      cnt_q   <= '0;
    end else begin
      mask_q  <= mask_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef LANE_CNTL_CHECK_EN
  logic cntl_err_q, cntl_err_d;
  logic cntl_mis;

  // Flag a fire whose lanes disagree or whose sod/eod contradict the word position.
  always_comb begin
    cntl_mis = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (mask_q[i] && (head_dat[i][DATA_W +: 2] != low_cntl)) begin
        cntl_mis = 1'b1;
      end
    end
    if ((cnt_q == '0) && !low_cntl[0]) begin
      cntl_mis = 1'b1;
    end
    if (low_cntl[1] != last) begin
      cntl_mis = 1'b1;
    end
    cntl_err_d = cntl_err_q;
    if (oob_acc) begin
      cntl_err_d = 1'b0;
    end else if (fire && cntl_mis) begin
      cntl_err_d = 1'b1;
    end
  end

  // Sticky error flag, cleared by the next OOB accept.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      cntl_err_q <= 1'b0;
    end else begin
      cntl_err_q <= cntl_err_d;
    end
  end

  assign bus.cntl_err = cntl_err_q;
`else
  assign bus.cntl_err = 1'b0;
`endif

  assign bus.oob_ready  = oob_rdy;
  assign bus.lane_ready = lane_rdy;
  assign bus.out_valid  = out_vld;
  assign bus.out_data   = out_dat;
  assign bus.out_cntl   = out_cntl_c;
  assign bus.op_done    = op_done_c;
endmodule

// File: tb/tb_stack_dn_lane_sync.sv
// Directed bench for stack_dn_lane_sync with a queue scoreboard of expected lockstep words.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// A lane/occupancy model predicts lane_ready, out_valid, oob_ready, op_done and cntl_err every cycle.
module tb_stack_dn_lane_sync;
  localparam int NL    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = 16;

  typedef struct {
    logic [NL*DW-1:0] dat;
    logic [1:0]       cntl;
    int               k;
  } exp_t;

  logic clk = 1'b0;
  logic reset_poweron;
  always #5 clk = ~clk;

  stack_dn_lane_sync_if #(.NUM_LANES(NL), .DATA_W(DW), .CNT_W(CW)) bus ();

  stack_dn_lane_sync #(.NUM_LANES(NL), .DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset_poweron (reset_poweron),
    .bus           (bus)
  );

  int tests = 0;
  int fails = 0;

  int sent [NL];
  int total [NL];
  int delay [NL];
  bit garbage [NL];
  bit pushed [NL];
  int bad_lane = -1;
  int base = 0;

  logic [NL-1:0] m_mask = '0;
  int            m_count = 0;
  int            fired = 0;
  bit            streaming = 1'b0;
  bit            done_exp = 1'b0;
  bit            err_exp = 1'b0;
  int            fires = 0;
  exp_t          sb [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_dat(input int i, input int k);
    return DW'(base + i * 16 + k);
  endfunction

  function automatic logic [1:0] word_cntl(input int i, input int k, input int n);
    if (i == bad_lane && k == 0) return 2'b11;
    return {(k == n - 1), (k == 0)};
  endfunction

  function automatic int low_lane(input logic [NL-1:0] m);
    for (int i = 0; i < NL; i++) if (m[i]) return i;
    return 0;
  endfunction

  task automatic setup(input logic [NL-1:0] mask, input int n);
    for (int i = 0; i < NL; i++) begin
      total[i]   = mask[i] ? n : 0;
      sent[i]    = 0;
      delay[i]   = 0;
      garbage[i] = 1'b0;
      pushed[i]  = 1'b0;
    end
  endtask

  task automatic drive_lanes();
    for (int i = 0; i < NL; i++) begin
      if (garbage[i]) begin
        bus.lane_valid[i]        = 1'b1;
        bus.lane_data[i*DW +: DW] = $urandom;
        bus.lane_cntl[2*i +: 2]  = 2'($urandom);
      end else begin
        bus.lane_valid[i]        = (delay[i] == 0) && (sent[i] < total[i]);
        bus.lane_data[i*DW +: DW] = word_dat(i, sent[i]);
        bus.lane_cntl[2*i +: 2]  = word_cntl(i, sent[i], total[i]);
      end
    end
  endtask

  task automatic tick();
    logic [NL-1:0] exp_rdy;
    bit            exp_vld, idle, fire, err_nxt;
    exp_t          e;
    @(negedge clk);
    idle    = !streaming && !done_exp;
    exp_rdy = '0;
    exp_vld = streaming;
    for (int i = 0; i < NL; i++) begin
      if (streaming && m_mask[i] && (sent[i] - fired) < DEPTH) exp_rdy[i] = 1'b1;
      if (m_mask[i] && (sent[i] - fired) == 0) exp_vld = 1'b0;
    end
    check("lane_ready", bus.lane_ready, exp_rdy);
    check("out_valid", bus.out_valid, exp_vld);
    check("oob_ready", bus.oob_ready, idle);
    check("op_done", bus.op_done, done_exp);
    check("cntl_err", bus.cntl_err, err_exp);
    done_exp = 1'b0;
    err_nxt  = err_exp;
    for (int i = 0; i < NL; i++) pushed[i] = bus.lane_valid[i] & bus.lane_ready[i];
    fire = bus.out_valid & bus.out_ready;
    if (fire && sb.size() > 0) begin
      fires++;
      e = sb.pop_front();
      for (int i = 0; i < NL; i++)
        check($sformatf("out_data[%0d] word %0d", i, e.k), bus.out_data[i*DW +: DW], e.dat[i*DW +: DW]);
      check($sformatf("out_cntl word %0d", e.k), bus.out_cntl, e.cntl);
`ifdef LANE_CNTL_CHECK_EN
      begin : err_model
        bit         mis;
        logic [1:0] lc;
        lc  = word_cntl(low_lane(m_mask), e.k, m_count);
        mis = 1'b0;
        for (int i = 0; i < NL; i++)
          if (m_mask[i] && word_cntl(i, e.k, m_count) != lc) mis = 1'b1;
        if (e.k == 0 && lc[0] != 1'b1) mis = 1'b1;
        if (lc[1] != (e.k == m_count - 1)) mis = 1'b1;
        if (mis) err_nxt = 1'b1;
      end
`endif
      fired++;
      if (e.k == m_count - 1) begin
        streaming = 1'b0;
        done_exp  = 1'b1;
      end
    end
    if (bus.oob_valid && idle) begin
      m_mask  = bus.oob_lane_mask;
      m_count = int'(bus.oob_num_words);
      fired   = 0;
      err_nxt = 1'b0;
      if (m_mask == '0 || m_count == 0) begin
        done_exp = 1'b1;
      end else begin
        streaming = 1'b1;
        for (int k = 0; k < m_count; k++) begin
          e.k    = k;
          e.cntl = word_cntl(low_lane(m_mask), k, m_count);
          e.dat  = '0;
          for (int i = 0; i < NL; i++) if (m_mask[i]) e.dat[i*DW +: DW] = word_dat(i, k);
          sb.push_back(e);
        end
      end
    end
    err_exp = err_nxt;
    @(posedge clk);
    #1;
    for (int i = 0; i < NL; i++) begin
      if (pushed[i]) sent[i]++;
      pushed[i] = 1'b0;
      if (delay[i] > 0) delay[i]--;
    end
    drive_lanes();
  endtask

  task automatic start_op(input logic [NL-1:0] mask, input int n);
    bus.oob_valid     = 1'b1;
    bus.oob_lane_mask = mask;
    bus.oob_num_words = CW'(n);
    drive_lanes();
    tick();
    bus.oob_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((streaming || done_exp) && n < max) begin
      tick();
      n++;
    end
    check("op_finished_in_budget", {63'b0, streaming || done_exp}, 0);
  endtask

  task automatic do_reset();
    reset_poweron  = 1'b1;
    bus.lane_valid = '0;
    bus.oob_valid  = 1'b0;
    @(posedge clk);
    #1;
    reset_poweron = 1'b0;
    setup('0, 0);
    streaming = 1'b0;
    done_exp  = 1'b0;
    err_exp   = 1'b0;
    m_mask    = '0;
    fired     = 0;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, n;
    logic [NL*DW-1:0] snap;
    reset_poweron     = 1'b1;
    bus.oob_valid     = 1'b0;
    bus.oob_lane_mask = '0;
    bus.oob_num_words = '0;
    bus.lane_valid    = '0;
    bus.lane_data     = '0;
    bus.lane_cntl     = '0;
    bus.out_ready     = 1'b1;
    setup('0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_poweron = 1'b0;

    // reset state
    check("rst_out_data_any", {63'b0, |bus.out_data}, 0);
    check("rst_out_cntl", bus.out_cntl, 0);
    check("rst_oob_ready", bus.oob_ready, 1);
    check("rst_lane_ready", bus.lane_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_op_done", bus.op_done, 0);
    check("rst_cntl_err", bus.cntl_err, 0);
    tick();

    // all lanes, 4 words each
    base = 0;
    setup('1, 4);
    f0 = fires;
    start_op('1, 4);
    wait_idle(100);
    check("all_lanes_fires", fires - f0, 4);
    tick();

    // sparse mask with a garbage-driving disabled lane
    base = 32'h200;
    setup(32'h5, 2);
    garbage[1] = 1'b1;
    f0 = fires;
    start_op(32'h5, 2);
    wait_idle(100);
    check("sparse_fires", fires - f0, 2);
    garbage[1] = 1'b0;
    tick();

    // lane 3 starts 5 cycles late
    base = 32'h400;
    setup(32'hF, 12);
    delay[3] = 5;
    f0 = fires;
    start_op(32'hF, 12);
    wait_idle(200);
    check("skew_fires", fires - f0, 12);
    tick();

    // downstream stall: heads frozen, lanes fill to DEPTH
    base = 32'h600;
    bus.out_ready = 1'b0;
    setup(32'hF, 12);
    f0 = fires;
    start_op(32'hF, 12);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    check("stall_valid_seen", bus.out_valid, 1);
    snap = bus.out_data;
    repeat (10) begin
      tick();
      for (int i = 0; i < 4; i++)
        check($sformatf("stall_stable[%0d]", i), bus.out_data[i*DW +: DW], snap[i*DW +: DW]);
    end
    check("stall_no_fire", fires - f0, 0);
    check("stall_full_not_ready", bus.lane_ready[3:0], 0);
    bus.out_ready = 1'b1;
    wait_idle(200);
    check("stall_fires", fires - f0, 12);
    tick();

    // zero count and zero mask complete at once
    setup(32'hF, 0);
    f0 = fires;
    start_op(32'hF, 0);
    tick();
    tick();
    setup('0, 5);
    start_op('0, 5);
    tick();
    tick();
    check("zero_op_fires", fires - f0, 0);

    // reset in the middle of an 8-word op, then a fresh op must see only new data
    base = 32'h800;
    setup(32'hF, 8);
    start_op(32'hF, 8);
    repeat (4) tick();
    do_reset();
    repeat (3) tick();
    base = 32'hA00;
    setup(32'h1, 1);
    f0 = fires;
    start_op(32'h1, 1);
    wait_idle(50);
    check("post_reset_fires", fires - f0, 1);
    tick();

    // lane 5 flags eod on word 0; error (if built) sticks until next accept
    base = 32'hC00;
    setup(32'h21, 3);
    bad_lane = 5;
    start_op(32'h21, 3);
    wait_idle(100);
    tick();
    tick();
`ifdef LANE_CNTL_CHECK_EN
    check("cntl_err_sticky", bus.cntl_err, 1);
`else
    check("cntl_err_tied", bus.cntl_err, 0);
`endif
    bad_lane = -1;
    setup(32'h1, 1);
    start_op(32'h1, 1);
    wait_idle(50);
    tick();
    check("cntl_err_cleared", bus.cntl_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
